sum_bcd_converter: RTL and testbench

//   Consumes the 9-bit unsigned sum from the 8-bit adder stage and converts it to packed BCD
//   (hundreds/tens/ones) for the display stage.

---
 rtl/sum_bcd_converter.sv | 113 +++++++++++
 tb/tb_sum_bcd_converter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_bcd_converter.sv
// ============================================================================
// Module      : sum_bcd_converter
// Description : Sequential double-dabble converter, binary adder sum -> packed
//               BCD, with valid/ready handshakes on input and output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_bcd_converter #(
    parameter int IN_W   = 9,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inValid,
    input  logic [IN_W-1:0]       inDat,
    output logic                  inReady,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [4*DIGITS-1:0]   outBcd
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_SR_W  = c_BCD_W + IN_W;
    localparam int c_CNT_W = $clog2(IN_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_SR_W-1:0]    sr_q, sr_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [c_BCD_W-1:0]   out_bcd_q, out_bcd_d;
    logic                 out_valid_q, out_valid_d;
    logic [c_SR_W-1:0]    sr_adj;
    logic [c_SR_W-1:0]    sr_shift;

    // Add-3 correction is decided on the pre-shift value for all digits at once.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_q[IN_W + 4*i +: 4] >= 4'd5) begin
                sr_adj[IN_W + 4*i +: 4] = sr_q[IN_W + 4*i +: 4] + 4'd3;
            end
        end
        sr_shift = {sr_adj[c_SR_W-2:0], 1'b0};
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        out_bcd_d   = out_bcd_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (inValid) begin
                    sr_d    = {{c_BCD_W{1'b0}}, inDat};
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_LAST_CNT) begin
                    out_bcd_d   = sr_shift[c_SR_W-1 -: c_BCD_W];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (outReady) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            out_bcd_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_bcd_q   <= out_bcd_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Readiness must not depend on inValid, so it is decoded from state alone.
    assign inReady  = (state_q == IDLE) && !rst;
    assign outValid = out_valid_q;
    assign outBcd   = out_bcd_q;

endmodule

`default_nettype wire

// File: tb/tb_sum_bcd_converter.sv
// ============================================================================
// Module      : tb_sum_bcd_converter
// Description : Directed self-checking bench for sum_bcd_converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_bcd_converter;

    localparam int IN_W   = 9;
    localparam int DIGITS = 3;

    logic            clk;
    logic            rst;
    logic            inValid;
    logic [IN_W-1:0] inDat;
    logic            inReady;
    logic            outValid;
    logic            outReady;
    logic [11:0]     outBcd;

    int n_cmp;
    int n_err;

    sum_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid),
        .inDat    (inDat),
        .inReady  (inReady),
        .outValid (outValid),
        .outReady (outReady),
        .outBcd   (outBcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for inReady, then presents one operand for exactly one edge.
    task automatic do_accept(input logic [IN_W-1:0] val, output bit ok);
        int guard;
        guard = 0;
        while (!inReady && guard < 40) begin
            tick();
            guard++;
        end
        ok      = inReady;
        inValid = 1'b1;
        inDat   = val;
        tick();
        inValid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles, output bit ok);
        cycles = 0;
        while (!outValid && cycles < 40) begin
            tick();
            cycles++;
        end
        ok = outValid;
    endtask

    task automatic test_reset();
        rst = 1'b1; inValid = 1'b0; inDat = '0; outReady = 1'b0;
        tick();
        tick();
        n_cmp += 3;
        if (inReady !== 1'b0) begin n_err++; $display("FAIL reset_inReady got=%b exp=0", inReady); end
        if (outValid !== 1'b0) begin n_err++; $display("FAIL reset_outValid got=%b exp=0", outValid); end
        if (outBcd !== 12'h000) begin n_err++; $display("FAIL reset_outBcd got=%h exp=000", outBcd); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (inReady !== 1'b1) begin n_err++; $display("FAIL reset_release_inReady got=%b exp=1", inReady); end
    endtask

    task automatic test_values();
        logic [IN_W-1:0] vals [8] = '{9'd0, 9'd510, 9'd511, 9'd9, 9'd10, 9'd99, 9'd100, 9'd255};
        logic [11:0]     exps [8] = '{12'h000, 12'h510, 12'h511, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255};
        int cyc;
        bit ok;
        for (int k = 0; k < 8; k++) begin
            do_accept(vals[k], ok);
            n_cmp += 2;
            if (!ok) begin n_err++; $display("FAIL val%0d_accept_timeout inReady=%b exp=1", k, inReady); end
            if (inReady !== 1'b0) begin n_err++; $display("FAIL val%0d_conv_inReady got=%b exp=0", k, inReady); end
            wait_valid(cyc, ok);
            n_cmp += 3;
            if (!ok) begin n_err++; $display("FAIL val%0d_outValid_timeout got=%b exp=1", k, outValid); end
            if (cyc != IN_W) begin n_err++; $display("FAIL val%0d_latency got=%0d exp=%0d", k, cyc, IN_W); end
            if (outBcd !== exps[k]) begin n_err++; $display("FAIL val%0d_bcd in=%0d got=%h exp=%h", k, vals[k], outBcd, exps[k]); end
            outReady = 1'b1;
            tick();
            outReady = 1'b0;
            n_cmp += 2;
            if (outValid !== 1'b0) begin n_err++; $display("FAIL val%0d_handshake_outValid got=%b exp=0", k, outValid); end
            if (inReady !== 1'b1) begin n_err++; $display("FAIL val%0d_handshake_inReady got=%b exp=1", k, inReady); end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit ok;
        do_accept(9'd77, ok);
        wait_valid(cyc, ok);
        n_cmp += 2;
        if (!ok) begin n_err++; $display("FAIL bp_outValid_timeout got=%b exp=1", outValid); end
        if (outBcd !== 12'h077) begin n_err++; $display("FAIL bp_bcd got=%h exp=077", outBcd); end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp += 3;
            if (outValid !== 1'b1) begin n_err++; $display("FAIL bp_hold_outValid cyc=%0d got=%b exp=1", c, outValid); end
            if (outBcd !== 12'h077) begin n_err++; $display("FAIL bp_hold_bcd cyc=%0d got=%h exp=077", c, outBcd); end
            if (inReady !== 1'b0) begin n_err++; $display("FAIL bp_hold_inReady cyc=%0d got=%b exp=0", c, inReady); end
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        n_cmp += 3;
        if (outValid !== 1'b0) begin n_err++; $display("FAIL bp_release_outValid got=%b exp=0", outValid); end
        if (inReady !== 1'b1) begin n_err++; $display("FAIL bp_release_inReady got=%b exp=1", inReady); end
        if (outBcd !== 12'h077) begin n_err++; $display("FAIL bp_idle_bcd_kept got=%h exp=077", outBcd); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit ok;
        do_accept(9'd123, ok);
        // Second operand is offered for the whole conversion and must be ignored.
        inValid = 1'b1;
        inDat   = 9'd456;
        wait_valid(cyc, ok);
        n_cmp += 3;
        if (!ok) begin n_err++; $display("FAIL b2b_first_timeout got=%b exp=1", outValid); end
        if (cyc != IN_W) begin n_err++; $display("FAIL b2b_first_latency got=%0d exp=%0d", cyc, IN_W); end
        if (outBcd !== 12'h123) begin n_err++; $display("FAIL b2b_first_bcd got=%h exp=123", outBcd); end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        n_cmp++;
        if (inReady !== 1'b1) begin n_err++; $display("FAIL b2b_idle_inReady got=%b exp=1", inReady); end
        tick();
        inValid = 1'b0;
        wait_valid(cyc, ok);
        n_cmp += 3;
        if (!ok) begin n_err++; $display("FAIL b2b_second_timeout got=%b exp=1", outValid); end
        if (cyc != IN_W) begin n_err++; $display("FAIL b2b_second_latency got=%0d exp=%0d", cyc, IN_W); end
        if (outBcd !== 12'h456) begin n_err++; $display("FAIL b2b_second_bcd got=%h exp=456", outBcd); end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    task automatic test_reset_mid_conv();
        int cyc;
        bit ok;
        bit seen;
        do_accept(9'd300, ok);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        n_cmp += 3;
        if (outValid !== 1'b0) begin n_err++; $display("FAIL midrst_outValid got=%b exp=0", outValid); end
        if (outBcd !== 12'h000) begin n_err++; $display("FAIL midrst_outBcd got=%h exp=000", outBcd); end
        if (inReady !== 1'b0) begin n_err++; $display("FAIL midrst_inReady got=%b exp=0", inReady); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (inReady !== 1'b1) begin n_err++; $display("FAIL midrst_release_inReady got=%b exp=1", inReady); end
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (outValid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_err++; $display("FAIL midrst_spurious_outValid got=1 exp=0"); end
        do_accept(9'd42, ok);
        wait_valid(cyc, ok);
        n_cmp += 3;
        if (!ok) begin n_err++; $display("FAIL midrst_new_timeout got=%b exp=1", outValid); end
        if (cyc != IN_W) begin n_err++; $display("FAIL midrst_new_latency got=%0d exp=%0d", cyc, IN_W); end
        if (outBcd !== 12'h042) begin n_err++; $display("FAIL midrst_new_bcd got=%h exp=042", outBcd); end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_values();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_conv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
